// File: rtl/mem_block_mover.sv
// Block copy/fill engine driving a flat byte-addressed simulation memory port.
// One memory access per clock: copy alternates READ/WRITE, fill issues WRITE only.
module mem_block_mover (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        fill,
  input  logic        byte_mode,
  input  logic [19:0] src,
  input  logic [19:0] dst,
  input  logic [15:0] len,
  input  logic [15:0] pattern,
  output logic        busy,
  output logic        done,
  output logic [19:0] mem_addr,
  output logic [15:0] mem_wr_data,
  input  logic [15:0] mem_rd_data,
  output logic        mem_we,
  output logic        mem_byte_m
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t      state_q, state_d;
  logic [19:0] src_ptr_q, src_ptr_d;
  logic [19:0] dst_ptr_q, dst_ptr_d;
  logic [15:0] count_q, count_d;
  logic [15:0] data_buf_q, data_buf_d;
  logic        fill_q, fill_d;
  logic        mode_q, mode_d;
  logic [19:0] step;

  assign step = mode_q ? 20'd1 : 20'd2;

  always_comb begin
    state_d    = state_q;
    src_ptr_d  = src_ptr_q;
    dst_ptr_d  = dst_ptr_q;
    count_d    = count_q;
    data_buf_d = data_buf_q;
    fill_d     = fill_q;
    mode_d     = mode_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          src_ptr_d  = src;
          dst_ptr_d  = dst;
          count_d    = len;
          data_buf_d = pattern;
          fill_d     = fill;
          mode_d     = byte_mode;
          if (len == 16'd0)
            state_d = DONE;
          else if (fill)
            state_d = WRITE;
          else
            state_d = READ;
        end
      end
      READ: begin
        // Byte reads arrive sign-extended; only [7:0] is ever written back.
        data_buf_d = mem_rd_data;
        src_ptr_d  = src_ptr_q + step;
        state_d    = WRITE;
      end
      WRITE: begin
        dst_ptr_d = dst_ptr_q + step;
        count_d   = count_q - 16'd1;
        if (count_q == 16'd1)
          state_d = DONE;
        else if (fill_q)
          state_d = WRITE;
        else
          state_d = READ;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      src_ptr_q  <= 20'd0;
      dst_ptr_q  <= 20'd0;
      count_q    <= 16'd0;
      data_buf_q <= 16'd0;
      fill_q     <= 1'b0;
      mode_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_ptr_q  <= src_ptr_d;
      dst_ptr_q  <= dst_ptr_d;
      count_q    <= count_d;
      data_buf_q <= data_buf_d;
      fill_q     <= fill_d;
      mode_q     <= mode_d;
    end
  end

  // Outputs decode only from registered state, never from start or mem_rd_data.
  always_comb begin
    busy        = (state_q == READ) || (state_q == WRITE);
    done        = (state_q == DONE);
    mem_we      = (state_q == WRITE);
    mem_byte_m  = busy && mode_q;
    mem_addr    = 20'd0;
    mem_wr_data = 16'd0;
    if (state_q == READ)
      mem_addr = src_ptr_q;
    else if (state_q == WRITE) begin
      mem_addr    = dst_ptr_q;
      mem_wr_data = data_buf_q;
    end
  end

endmodule

// File: tb/tb_mem_block_mover.sv
// Directed bench for mem_block_mover with a little-endian byte memory model.
module tb_mem_block_mover;

  logic        clk = 1'b0;
  logic        rst, start, fill, byte_mode;
  logic [19:0] src, dst;
  logic [15:0] len, pattern;
  logic        busy, done, mem_we, mem_byte_m;
  logic [19:0] mem_addr;
  logic [15:0] mem_wr_data, mem_rd_data;

  logic [7:0]  mem [0:1048575];
  logic [19:0] addr_p1;
  logic        pl_we;
  logic [19:0] pl_addr;
  logic [7:0]  pl_data;

  int errors = 0;
  int checks = 0;

  int          done_cyc, done_cnt, busy_cnt, we_cnt;
  logic [19:0] a1, a2;
  logic [15:0] w2;

  always #5 clk = ~clk;

  mem_block_mover dut (
    .clk(clk), .rst(rst), .start(start), .fill(fill), .byte_mode(byte_mode),
    .src(src), .dst(dst), .len(len), .pattern(pattern),
    .busy(busy), .done(done), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data), .mem_we(mem_we), .mem_byte_m(mem_byte_m)
  );

  assign addr_p1 = mem_addr + 20'd1;
  assign mem_rd_data = mem_byte_m ? {{8{mem[mem_addr][7]}}, mem[mem_addr]}
                                  : {mem[addr_p1], mem[mem_addr]};

  always @(posedge clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    if (mem_we) begin
      mem[mem_addr] <= mem_wr_data[7:0];
      if (!mem_byte_m) mem[addr_p1] <= mem_wr_data[15:8];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [19:0] a, input logic [7:0] d);
    pl_addr = a;
    pl_data = d;
    pl_we   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    pl_we   = 1'b0;
  endtask

  function automatic logic [15:0] word_at(input logic [19:0] a);
    logic [19:0] b;
    b = a + 20'd1;
    return {mem[b], mem[a]};
  endfunction

  // Starts at a negedge in cycle 0, samples every cycle 1..limit at the negedge.
  task automatic run_op(input int limit);
    done_cyc = 0; done_cnt = 0; busy_cnt = 0; we_cnt = 0;
    a1 = '0; a2 = '0; w2 = '0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= limit; k++) begin
      if (busy)   busy_cnt++;
      if (mem_we) we_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = k;
      end
      if (k == 1) a1 = mem_addr;
      if (k == 2) begin
        a2 = mem_addr;
        w2 = mem_wr_data;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; fill = 1'b0; byte_mode = 1'b0;
    src = '0; dst = '0; len = '0; pattern = '0;
    pl_we = 1'b0; pl_addr = '0; pl_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wr_data, 0);
    check("rst_bytem", mem_byte_m, 0);
    rst = 1'b0;
    @(negedge clk);

    // Word copy of four words
    preload(20'h01000, 8'h11); preload(20'h01001, 8'h11);
    preload(20'h01002, 8'h22); preload(20'h01003, 8'h22);
    preload(20'h01004, 8'h33); preload(20'h01005, 8'h33);
    preload(20'h01006, 8'h44); preload(20'h01007, 8'h44);
    src = 20'h01000; dst = 20'h02000; len = 16'd4; fill = 1'b0; byte_mode = 1'b0;
    run_op(12);
    check("copy_done_cyc", done_cyc, 9);
    check("copy_done_cnt", done_cnt, 1);
    check("copy_busy_cnt", busy_cnt, 8);
    check("copy_we_cnt", we_cnt, 4);
    check("copy_addr_c1", a1, 20'h01000);
    check("copy_addr_c2", a2, 20'h02000);
    check("copy_wdata_c2", w2, 16'h1111);
    check("copy_w0", word_at(20'h02000), 16'h1111);
    check("copy_w1", word_at(20'h02002), 16'h2222);
    check("copy_w2", word_at(20'h02004), 16'h3333);
    check("copy_w3", word_at(20'h02006), 16'h4444);

    // Byte fill of three bytes, neighbour untouched
    preload(20'h03003, 8'h99);
    dst = 20'h03000; len = 16'd3; fill = 1'b1; byte_mode = 1'b1; pattern = 16'hABCD;
    src = 20'h0ABCD;
    run_op(7);
    check("bfill_done_cyc", done_cyc, 4);
    check("bfill_we_cnt", we_cnt, 3);
    check("bfill_b0", mem[20'h03000], 8'hCD);
    check("bfill_b1", mem[20'h03001], 8'hCD);
    check("bfill_b2", mem[20'h03002], 8'hCD);
    check("bfill_b3", mem[20'h03003], 8'h99);

    // Zero-length copy
    src = 20'h01000; dst = 20'h07000; len = 16'd0; fill = 1'b0; byte_mode = 1'b0;
    run_op(5);
    check("len0_done_cyc", done_cyc, 1);
    check("len0_done_cnt", done_cnt, 1);
    check("len0_we_cnt", we_cnt, 0);
    check("len0_busy_cnt", busy_cnt, 0);

    // Word fill across the top of the address space
    dst = 20'hFFFFE; len = 16'd2; fill = 1'b1; byte_mode = 1'b0; pattern = 16'h55AA;
    run_op(6);
    check("wrap_done_cyc", done_cyc, 3);
    check("wrap_b_fffe", mem[20'hFFFFE], 8'hAA);
    check("wrap_b_ffff", mem[20'hFFFFF], 8'h55);
    check("wrap_b_0000", mem[20'h00000], 8'hAA);
    check("wrap_b_0001", mem[20'h00001], 8'h55);

    // Overlapping ascending byte copy replicates the first byte
    preload(20'h00100, 8'h7E);
    for (int i = 1; i <= 4; i++) preload(20'h00100 + 20'(i), 8'(i));
    src = 20'h00100; dst = 20'h00101; len = 16'd4; fill = 1'b0; byte_mode = 1'b1;
    run_op(11);
    check("ovl_done_cyc", done_cyc, 9);
    for (int i = 1; i <= 4; i++)
      check($sformatf("ovl_b%0d", i), mem[20'h00100 + 20'(i)], 8'h7E);

    // Abort a long copy with reset during its third cycle
    preload(20'h04000, 8'h01); preload(20'h04001, 8'h02);
    preload(20'h04002, 8'h03); preload(20'h04003, 8'h04);
    preload(20'h05000, 8'h00); preload(20'h05001, 8'h00);
    preload(20'h05002, 8'h00); preload(20'h05003, 8'h00);
    src = 20'h04000; dst = 20'h05000; len = 16'd8; fill = 1'b0; byte_mode = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort_we", mem_we, 0);
    check("abort_busy", busy, 0);
    done_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      if (done || busy) done_cnt++;
      @(negedge clk);
    end
    check("abort_quiet", done_cnt, 0);
    check("abort_first_w", word_at(20'h05000), 16'h0201);
    check("abort_second_w", word_at(20'h05002), 16'h0000);

    // Fresh operation after abort uses newly latched pointers
    src = 20'h04002; dst = 20'h06000; len = 16'd1; fill = 1'b0; byte_mode = 1'b0;
    run_op(5);
    check("fresh_done_cyc", done_cyc, 3);
    check("fresh_addr_c1", a1, 20'h04002);
    check("fresh_w", word_at(20'h06000), 16'h0403);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
